// File: rtl/puf_response_sequencer_if.sv
// Key word stream between the PUF response sequencer and the key consumer.
// The sequencer is the master (drives words); the consumer is the slave (drives ready).
interface puf_response_sequencer_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] key_word;
  logic              key_valid;
  logic              key_ready;
  logic              key_last;
  logic              word_unstable;

  modport master (
    output key_word, key_valid, key_last, word_unstable,
    input  key_ready
  );

  modport slave (
    input  key_word, key_valid, key_last, word_unstable,
    output key_ready
  );
endinterface

// File: rtl/puf_response_sequencer.sv
// Sequences the PUF generator through three settle/sample passes, majority-votes
// the samples into a key and streams it out word by word with unstable-word flags.
module puf_response_sequencer #(
  parameter int RESP_W        = 1024,
  parameter int WORD_W        = 32,
  parameter int SETTLE_CYCLES = 16,
  parameter int RELAX_CYCLES  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            challenge,
  output logic                  busy,
  output logic                  done,
  output logic                  puf_enable,
  output logic [1:0]            puf_control,
  input  logic [RESP_W-1:0]     puf_response,
  puf_response_sequencer_if.master key
);

  localparam int NW    = RESP_W / WORD_W;
  localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;
  localparam int MAXC  = (SETTLE_CYCLES > RELAX_CYCLES) ? SETTLE_CYCLES : RELAX_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    RELAX,
    VOTE,
    STREAM
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         k_q;
  logic [IDX_W-1:0]   idx_q;
  logic [1:0]         chal_q;
  logic [RESP_W-1:0]  s0_q, s1_q, s2_q, key_q;
  logic [RESP_W-1:0]  key_d, diff;
  logic [NW-1:0]      mask_q, mask_d;
  logic               done_q;
  logic               hs, last_word;

  // Next-state logic and outputs
  always_comb begin
    state_d           = state_q;
    busy              = 1'b0;
    puf_enable        = 1'b0;
    key.key_valid     = 1'b0;
    key.key_word      = '0;
    key.key_last      = 1'b0;
    key.word_unstable = 1'b0;
    last_word         = (idx_q == IDX_W'(NW - 1));
    hs                = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) state_d = SETTLE;
      end
      SETTLE: begin
        busy       = 1'b1;
        puf_enable = 1'b1;
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) state_d = SAMPLE;
      end
      SAMPLE: begin
        busy       = 1'b1;
        puf_enable = 1'b1;
        state_d    = (k_q == 2'd2) ? VOTE : RELAX;
      end
      RELAX: begin
        busy = 1'b1;
        if (cnt_q == CNT_W'(RELAX_CYCLES - 1)) state_d = SETTLE;
      end
      VOTE: begin
        busy    = 1'b1;
        state_d = STREAM;
      end
      STREAM: begin
        busy              = 1'b1;
        key.key_valid     = 1'b1;
        key.key_word      = key_q[idx_q*WORD_W +: WORD_W];
        key.key_last      = last_word;
        key.word_unstable = mask_q[idx_q];
        hs                = key.key_ready;
        if (hs && last_word) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bitwise 2-of-3 vote and per-word disagreement flags
  always_comb begin
    key_d  = (s0_q & s1_q) | (s0_q & s2_q) | (s1_q & s2_q);
    diff   = (s0_q ^ s1_q) | (s0_q ^ s2_q);
    mask_d = '0;
    for (int unsigned w = 0; w < NW; w++) begin
      mask_d[w] = |diff[w*WORD_W +: WORD_W];
    end
  end

  assign puf_control = chal_q;
  assign done        = done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      k_q    <= '0;
      idx_q  <= '0;
      chal_q <= '0;
      s0_q   <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      key_q  <= '0;
      mask_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= hs && last_word;

      // Phase counter restarts on every state change
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (state_q == SETTLE || state_q == RELAX) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (state_q == IDLE && start) begin
        chal_q <= challenge;
        k_q    <= '0;
      end

      if (state_q == SAMPLE) begin
        case (k_q)
          2'd0:    s0_q <= puf_response;
          2'd1:    s1_q <= puf_response;
          default: s2_q <= puf_response;
        endcase
        if (k_q != 2'd2) k_q <= k_q + 1'b1;
      end

      if (state_q == VOTE) begin
        key_q  <= key_d;
        mask_q <= mask_d;
        idx_q  <= '0;
      end

      if (hs) begin
        idx_q <= last_word ? '0 : idx_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_puf_response_sequencer.sv
// Randomized bench for puf_response_sequencer against a bit-count majority model
// of the three enable episodes and a cycle-indexed timing model.
module tb_puf_response_sequencer;

  localparam int RESP_W = 1024;
  localparam int WORD_W = 32;
  localparam int NW     = RESP_W / WORD_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [1:0]        challenge;
  logic              busy, done, puf_enable;
  logic [1:0]        puf_control;
  logic [RESP_W-1:0] puf_response = '0;

  logic [RESP_W-1:0] resp_set [3];
  int                ep = 0;
  bit                en_prev = 1'b0;

  int checks = 0;
  int errors = 0;

  puf_response_sequencer_if #(.WORD_W(WORD_W)) kif ();

  puf_response_sequencer #(
    .RESP_W        (RESP_W),
    .WORD_W        (WORD_W),
    .SETTLE_CYCLES (16),
    .RELAX_CYCLES  (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .challenge    (challenge),
    .busy         (busy),
    .done         (done),
    .puf_enable   (puf_enable),
    .puf_control  (puf_control),
    .puf_response (puf_response),
    .key          (kif)
  );

  always #5 clk = ~clk;

  // PUF generator model: each enable-high episode presents the next sample value
  always @(negedge clk) begin
    if (!busy) ep = 0;
    else if (puf_enable && !en_prev && ep < 3) ep = ep + 1;
    en_prev = puf_enable;
    puf_response = resp_set[(ep > 0) ? ep - 1 : 0];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RESP_W-1:0] rand_resp();
    logic [RESP_W-1:0] r;
    for (int i = 0; i < RESP_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [RESP_W-1:0] flip_bits(input logic [RESP_W-1:0] v, input int n);
    int p;
    for (int i = 0; i < n; i++) begin
      p = $urandom_range(RESP_W - 1, 0);
      v[p] = ~v[p];
    end
    return v;
  endfunction

  // rmode: 0 always ready, 1 repeating 1,0,0,1, 2 random
  task automatic do_key(input logic [1:0] ch, input int rmode, input bit pulse_mid, input int rst_word);
    logic [RESP_W-1:0] exp_key;
    logic [NW-1:0]     exp_mask;
    logic [WORD_W-1:0] prev_word;
    int  ones, idx, en_err, ctl_err, sc;
    bit  fin, stalled, exp_en, kr;

    exp_key  = '0;
    exp_mask = '0;
    for (int b = 0; b < RESP_W; b++) begin
      ones = int'(resp_set[0][b]) + int'(resp_set[1][b]) + int'(resp_set[2][b]);
      exp_key[b] = (ones >= 2);
      if (ones == 1 || ones == 2) exp_mask[b / WORD_W] = 1'b1;
    end

    idx = 0; en_err = 0; ctl_err = 0; sc = 0;
    fin = 0; stalled = 0; prev_word = '0;

    @(negedge clk);
    start = 1'b1;
    challenge = ch;
    @(posedge clk);
    for (int c = 0; c < 3000 && !fin; c++) begin
      @(negedge clk);
      if (c == 0) begin
        start = 1'b0;
        challenge = 2'($urandom);
      end
      if (pulse_mid && c == 5) begin
        start = 1'b1;
        challenge = ~ch;
      end
      if (pulse_mid && c == 6) start = 1'b0;

      if (c < 60) begin
        exp_en = (c < 59) && ((c % 21) < 17);
        if (puf_enable !== exp_en || kif.key_valid !== 1'b0 || busy !== 1'b1) en_err++;
      end
      if (busy && puf_control !== ch) ctl_err++;
      if (c == 60) check("latency_valid", kif.key_valid, 1);

      if (c >= 60) begin
        if (stalled) check("stall_hold", kif.key_word, prev_word);
        check("key_valid", kif.key_valid, 1);
        check("key_word", kif.key_word, exp_key[idx*WORD_W +: WORD_W]);
        check("word_unstable", kif.word_unstable, exp_mask[idx]);
        check("key_last", kif.key_last, (idx == NW - 1));
        if (idx == rst_word) begin
          rst_n = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
          check("reset_outputs",
                {busy, done, puf_enable, kif.key_valid, kif.key_last, kif.word_unstable,
                 puf_control, kif.key_word}, '0);
          kif.key_ready = 1'b0;
          fin = 1;
        end else begin
          case (rmode)
            0:       kr = 1'b1;
            1:       kr = (sc % 4 == 0) || (sc % 4 == 3);
            default: kr = $urandom_range(1, 0) == 1;
          endcase
          sc++;
          kif.key_ready = kr;
          stalled = !kr;
          prev_word = kif.key_word;
          if (kr) begin
            idx++;
            if (idx == NW) begin
              @(negedge clk);
              check("done_pulse", done, 1);
              check("valid_after_last", kif.key_valid, 0);
              check("busy_after_last", busy, 0);
              kif.key_ready = 1'b0;
              @(negedge clk);
              check("done_single", done, 0);
              check("no_second_stream", busy, 0);
              fin = 1;
            end
          end
        end
      end
    end
    check("enable_pattern", en_err, 0);
    check("control_hold", ctl_err, 0);
    check("completed", fin, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    challenge = 2'b00;
    kif.key_ready = 1'b0;
    for (int i = 0; i < 3; i++) resp_set[i] = '0;
    repeat (3) @(negedge clk);
    check("reset_state",
          {busy, done, puf_enable, kif.key_valid, kif.key_last, kif.word_unstable,
           puf_control, kif.key_word}, '0);
    rst_n = 1'b1;

    // Constant pattern, always ready
    for (int i = 0; i < 3; i++) resp_set[i] = {(RESP_W / 8){8'hA5}};
    do_key(2'b10, 0, 0, -1);

    // Single-bit disturbance in the middle sample only
    resp_set[0] = rand_resp();
    resp_set[2] = resp_set[0];
    resp_set[1] = resp_set[0];
    resp_set[1][40] = ~resp_set[1][40];
    do_key(2'($urandom), 1, 0, -1);

    // Restart attempt during settle, random ready
    resp_set[0] = rand_resp();
    resp_set[1] = flip_bits(resp_set[0], 3);
    resp_set[2] = flip_bits(resp_set[0], 2);
    do_key(2'b01, 2, 1, -1);

    // Reset mid-stream at word 5, then a full fresh key
    do_key(2'b11, 0, 0, 5);
    resp_set[1] = flip_bits(resp_set[1], 4);
    do_key(2'b00, 1, 0, -1);

    for (int t = 0; t < 3; t++) begin
      resp_set[0] = rand_resp();
      resp_set[1] = flip_bits(resp_set[0], $urandom_range(5, 0));
      resp_set[2] = flip_bits(resp_set[0], $urandom_range(5, 0));
      do_key(2'($urandom), $urandom_range(2, 0), 0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
